pico_sequencer: RTL and testbench



---
 rtl/pico_sequencer.sv | 125 ++++++++++++
 tb/tb_pico_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pico_sequencer.sv
// Multi-cycle control FSM for the pico MIPS core: fetch/decode/exec/mult-wait/writeback sequencing,
// program counter ownership, multiplier handshake with timeout, conditional branch.
module pico_sequencer #(
   parameter int PC_WIDTH        = 6,
   parameter int MULT_MAX_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [1:0]          instr,
   input  logic [PC_WIDTH-1:0] branch_offset,
   input  logic                flag_n,
   input  logic                mult_done,
   output logic [PC_WIDTH-1:0] pc,
   output logic                ir_load,
   output logic                alu_en,
   output logic                ram_en,
   output logic                mult_start,
   output logic                reg_we,
   output logic                busy,
   output logic                mult_err,
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXEC      = 3'd3,
      S_MULT_WAIT = 3'd4,
      S_WB        = 3'd5,
      S_ERROR     = 3'd6
   } state_t;

   localparam logic [1:0] OP_ADD  = 2'd0;
   localparam logic [1:0] OP_IMM  = 2'd1;
   localparam logic [1:0] OP_MULT = 2'd2;
   localparam logic [1:0] OP_BRAN = 2'd3;

   localparam int CW = $clog2(MULT_MAX_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MULT_MAX_CYCLES - 1);

   state_t              cur_state, nxt_state;
   logic [PC_WIDTH-1:0] pc_nxt;
   logic [1:0]          opcode, opcode_nxt;
   logic [CW-1:0]       wait_cnt, wait_cnt_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= S_IDLE;
         pc        <= '0;
         opcode    <= OP_ADD;
         wait_cnt  <= '0;
      end else begin
         cur_state <= nxt_state;
         pc        <= pc_nxt;
         opcode    <= opcode_nxt;
         wait_cnt  <= wait_cnt_nxt;
      end
   end

   always_comb begin
      nxt_state    = cur_state;
      pc_nxt       = pc;
      opcode_nxt   = opcode;
      wait_cnt_nxt = wait_cnt;
      ir_load      = 1'b0;
      alu_en       = 1'b0;
      ram_en       = 1'b0;
      mult_start   = 1'b0;
      reg_we       = 1'b0;
      case (cur_state)
         S_IDLE: if (run) nxt_state = S_FETCH;
         S_FETCH: begin
            ir_load    = 1'b1;
            opcode_nxt = instr;
            nxt_state  = S_DECODE;
         end
         S_DECODE: begin
            if (opcode == OP_MULT) begin
               ram_en       = 1'b1;
               mult_start   = 1'b1;
               wait_cnt_nxt = '0;
               nxt_state    = S_MULT_WAIT;
            end else begin
               ram_en    = (opcode == OP_ADD);
               nxt_state = S_EXEC;
            end
         end
         S_EXEC: begin
            if (opcode == OP_BRAN) begin
               // offset is already PC_WIDTH wide, so the modular add is the sign-extended add
               pc_nxt    = flag_n ? pc + branch_offset : pc + PC_WIDTH'(1);
               nxt_state = run ? S_FETCH : S_IDLE;
            end else begin
               alu_en    = (opcode == OP_ADD);
               ram_en    = (opcode == OP_ADD);
               nxt_state = S_WB;
            end
         end
         S_MULT_WAIT: begin
            // done takes priority over a timeout landing on the same cycle
            if (mult_done) begin
               nxt_state = S_WB;
            end else if (wait_cnt == CNT_LAST) begin
               nxt_state = S_ERROR;
            end else begin
               wait_cnt_nxt = wait_cnt + CW'(1);
            end
         end
         S_WB: begin
            reg_we    = 1'b1;
            pc_nxt    = pc + PC_WIDTH'(1);
            nxt_state = run ? S_FETCH : S_IDLE;
         end
         S_ERROR: nxt_state = S_ERROR;
         default: nxt_state = S_IDLE;
      endcase
   end

   assign busy     = (cur_state != S_IDLE) && (cur_state != S_ERROR);
   assign mult_err = (cur_state == S_ERROR);
   assign state    = cur_state;

endmodule

// File: tb/tb_pico_sequencer.sv
// Randomized bench: each instruction is expanded into its expected per-cycle output schedule.
module tb_pico_sequencer;

   localparam logic [1:0] ADD = 2'd0, IMM = 2'd1, MULT = 2'd2, BRAN = 2'd3;

   logic       clk, reset, run, flag_n, mult_done;
   logic [1:0] instr;
   logic [5:0] branch_offset, pc;
   logic       ir_load, alu_en, ram_en, mult_start, reg_we, busy, mult_err;
   logic [2:0] state;

   int nvec = 0;
   int nmis = 0;
   logic [5:0] m_pc;
   int status;

   pico_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .instr(instr),
      .branch_offset(branch_offset), .flag_n(flag_n), .mult_done(mult_done),
      .pc(pc), .ir_load(ir_load), .alu_en(alu_en), .ram_en(ram_en),
      .mult_start(mult_start), .reg_we(reg_we), .busy(busy),
      .mult_err(mult_err), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [15:0] obs = {pc, ir_load, alu_en, ram_en, mult_start, reg_we, busy, mult_err, state};

   // strobe field order: {ir_load, alu_en, ram_en, mult_start, reg_we}
   function automatic logic [15:0] ev(input logic [2:0] st, input logic [5:0] p, input logic [4:0] s);
      logic b, e;
      b = (st != 3'd0) && (st != 3'd6);
      e = (st == 3'd6);
      return {p, s, b, e, st};
   endfunction

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
      nvec++;
      if (got !== want) begin
         nmis++;
         $display("FAIL %s: got pc=%0d strb=%b busy=%b err=%b st=%0d, want pc=%0d strb=%b busy=%b err=%b st=%0d",
                  tag, got[15:10], got[9:5], got[4], got[3], got[2:0],
                  want[15:10], want[9:5], want[4], want[3], want[2:0]);
      end
   endtask

   task automatic rnd();
      run           = 1'($urandom);
      mult_done     = 1'($urandom);
      flag_n        = 1'($urandom);
      branch_offset = 6'($urandom);
      instr         = 2'($urandom);
   endtask

   task automatic cyc(input string tag, input logic [15:0] want);
      @(negedge clk);
      check_eq(tag, obs, want);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_phase();
      int n;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
         rnd();
         run = (j == n - 1);
         cyc("idle", ev(3'd0, m_pc, 5'b0));
      end
   endtask

   // k: MULT_WAIT cycle on which done arrives (0 = never); rst_at: MULT_WAIT cycle to reset on
   // st: 0 = retired normally, 1 = stuck in ERROR, 2 = reset back to IDLE
   task automatic do_instr(input logic [1:0] op, input int k, input logic fl, input logic [5:0] off,
                           input logic run_next, input int rst_at, output int st);
      st = 0;
      rnd();
      instr = op;
      cyc("fetch", ev(3'd1, m_pc, 5'b10000));
      rnd();
      cyc("decode", ev(3'd2, m_pc, op == ADD ? 5'b00100 : op == MULT ? 5'b00110 : 5'b00000));
      if (op == ADD || op == IMM) begin
         rnd();
         cyc("exec", ev(3'd3, m_pc, op == ADD ? 5'b01100 : 5'b00000));
         rnd();
         run = run_next;
         cyc("wb", ev(3'd5, m_pc, 5'b00001));
         m_pc = m_pc + 6'd1;
      end else if (op == BRAN) begin
         rnd();
         flag_n = fl;
         branch_offset = off;
         run = run_next;
         cyc("bran_exec", ev(3'd3, m_pc, 5'b00000));
         m_pc = fl ? m_pc + off : m_pc + 6'd1;
      end else begin
         for (int i = 1; i <= 16; i++) begin
            rnd();
            mult_done = (i == k);
            if (i == rst_at) reset = 1'b1;
            cyc("mult_wait", ev(3'd4, m_pc, 5'b00000));
            if (reset) begin
               reset = 1'b0;
               m_pc = '0;
               st = 2;
               return;
            end
            if (i == k) break;
         end
         if (k >= 1 && k <= 16) begin
            rnd();
            run = run_next;
            cyc("mult_wb", ev(3'd5, m_pc, 5'b00001));
            m_pc = m_pc + 6'd1;
         end else begin
            st = 1;
         end
      end
   endtask

   task automatic follow(input logic run_next, input int st);
      if (st == 1) begin
         for (int j = 0; j < 3; j++) begin
            rnd();
            cyc("error", ev(3'd6, m_pc, 5'b0));
         end
         rnd();
         reset = 1'b1;
         cyc("error_rst", ev(3'd6, m_pc, 5'b0));
         reset = 1'b0;
         m_pc = '0;
         idle_phase();
      end else if (st == 2 || !run_next) begin
         idle_phase();
      end
   endtask

   task automatic instr_full(input logic [1:0] op, input int k, input logic fl, input logic [5:0] off,
                             input logic run_next, input int rst_at);
      do_instr(op, k, fl, off, run_next, rst_at, status);
      follow(run_next, status);
   endtask

   initial begin
      reset = 1'b1;
      rnd();
      m_pc = '0;
      @(posedge clk);
      #1;
      cyc("reset", ev(3'd0, 6'd0, 5'b0));
      reset = 1'b0;
      idle_phase();

      for (int i = 0; i < 3; i++) instr_full(ADD, 0, 0, 0, 1'b1, 0);
      instr_full(BRAN, 0, 1'b1, 6'd10 - m_pc, 1'b1, 0);
      instr_full(BRAN, 0, 1'b1, 6'h3C, 1'b1, 0);
      instr_full(BRAN, 0, 1'b1, 6'd4, 1'b1, 0);
      instr_full(BRAN, 0, 1'b0, 6'h3C, 1'b1, 0);
      instr_full(BRAN, 0, 1'b1, 6'd63 - m_pc, 1'b1, 0);
      instr_full(IMM, 0, 0, 0, 1'b1, 0);
      instr_full(MULT, 5, 0, 0, 1'b1, 0);
      instr_full(MULT, 16, 0, 0, 1'b1, 0);
      instr_full(BRAN, 0, 1'b1, 6'd0, 1'b1, 0);
      instr_full(MULT, 0, 0, 0, 1'b1, 0);
      instr_full(ADD, 0, 0, 0, 1'b1, 0);
      instr_full(MULT, 0, 0, 0, 1'b1, 3);
      instr_full(ADD, 0, 0, 0, 1'b0, 0);

      for (int n = 0; n < 300; n++) begin
         logic [1:0] op;
         int k, ra;
         op = 2'($urandom);
         k  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 16);
         ra = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 16) : 0;
         instr_full(op, k, 1'($urandom), 6'($urandom), $urandom_range(0, 3) != 0, ra);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
